// File: rtl/booth_r4_mult.sv
// Radix-4 (modified Booth) sequential multiplier, signed/unsigned per operation, start/ready/done handshake.
// Optional zero-operand short-cut enabled by defining BOOTH_ZERO_SKIP_EN.
module booth_r4_mult #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   P,
    output logic                 ready,
    output logic                 done
);
    localparam int ITER = WIDTH / 2 + 1;
    localparam int EW   = WIDTH + 2;
    localparam int MW   = WIDTH + 3;
    localparam int AW   = 2 * WIDTH + 4;
    localparam int CW   = $clog2(ITER + 1);

    typedef enum logic {IDLE, CALC} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   acc;
    logic [AW-1:0]   mcand;
    logic [MW-1:0]   mplier;
    logic [AW-1:0]   pp;
    logic [AW-1:0]   acc_next;
    logic [EW-1:0]   a_ext;
    logic [EW-1:0]   b_ext;
    logic            last_iter;
`ifdef BOOTH_ZERO_SKIP_EN
    logic            zpend;
`endif

    // Two extra MSBs keep the top triplet valid for both unsigned and most-negative signed operands
    assign a_ext     = {{2{signed_mode & A[WIDTH-1]}}, A};
    assign b_ext     = {{2{signed_mode & B[WIDTH-1]}}, B};
    assign last_iter = (cnt == CW'(ITER - 1));

    always_comb begin
        pp = '0;
        case (mplier[2:0])
            3'b001, 3'b010: pp = mcand;
            3'b011:         pp = mcand << 1;
            3'b100:         pp = -(mcand << 1);
            3'b101, 3'b110: pp = -mcand;
            default:        pp = '0;
        endcase
        acc_next = acc + pp;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            P      <= '0;
            ready  <= 1'b1;
            done   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
`ifdef BOOTH_ZERO_SKIP_EN
            zpend  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    ready <= 1'b1;
`ifdef BOOTH_ZERO_SKIP_EN
                    // A zero-operand request completes one edge after acceptance; new starts wait for it
                    if (zpend) begin
                        P     <= '0;
                        done  <= 1'b1;
                        zpend <= 1'b0;
                    end else if (start && (A == '0 || B == '0)) begin
                        zpend <= 1'b1;
                    end else if (start) begin
`else
                    if (start) begin
`endif
                        mcand  <= {{(AW - EW){a_ext[EW-1]}}, a_ext};
                        mplier <= {b_ext, 1'b0};
                        acc    <= '0;
                        cnt    <= '0;
                        ready  <= 1'b0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 2;
                    mplier <= {{2{mplier[MW-1]}}, mplier[MW-1:2]};
                    cnt    <= cnt + CW'(1);
                    if (last_iter) begin
                        P     <= acc_next[2*WIDTH-1:0];
                        done  <= 1'b1;
                        ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_r4_mult.sv
// Self-checking bench for booth_r4_mult: WIDTH=4 and WIDTH=8 instances, vector table,
// handshake/reset corner sequences and a random sweep against an integer reference product.
module tb_booth_r4_mult;
    logic        clk;
    logic        reset;
    logic        s4, sm4, s8, sm8;
    logic [3:0]  a4, b4;
    logic [7:0]  a8, b8;
    logic [7:0]  p4;
    logic [15:0] p8;
    logic        r4, d4, r8, d8;

    int n_cmp = 0;
    int n_bad = 0;

    booth_r4_mult #(.WIDTH(4)) u4 (
        .clk(clk), .reset(reset), .start(s4), .signed_mode(sm4),
        .A(a4), .B(b4), .P(p4), .ready(r4), .done(d4)
    );
    booth_r4_mult #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .start(s8), .signed_mode(sm8),
        .A(a8), .B(b8), .P(p8), .ready(r8), .done(d8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          w;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sm;
        logic [15:0] p;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_mult(input int w, input logic [7:0] a,
                                             input logic [7:0] b, input logic sm);
        longint x, y, r, m;
        m = (longint'(1) << w) - 1;
        x = longint'(a) & m;
        y = longint'(b) & m;
        if (sm && ((x >> (w - 1)) & 1) == 1) x = x - (longint'(1) << w);
        if (sm && ((y >> (w - 1)) & 1) == 1) y = y - (longint'(1) << w);
        r = x * y;
        r = r & ((longint'(1) << (2 * w)) - 1);
        return r[15:0];
    endfunction

    function automatic int exp_lat(input int w, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] m;
        m = (w == 4) ? 8'h0F : 8'hFF;
`ifdef BOOTH_ZERO_SKIP_EN
        if ((a & m) == 8'h00 || (b & m) == 8'h00) return 1;
`endif
        return w / 2 + 1;
    endfunction

    function automatic bit cur_done(input int w);
        return (w == 4) ? d4 : d8;
    endfunction

    function automatic bit cur_ready(input int w);
        return (w == 4) ? r4 : r8;
    endfunction

    // One operation: returns captured product, measured latency, and handshake sanity flags
    task automatic do_op(input int w, input logic [7:0] a, input logic [7:0] b, input logic sm,
                         output logic [15:0] p, output int lat, output bit rdy_ok, output bit pulse_ok);
        int el;
        el = exp_lat(w, a, b);
        @(posedge clk); #1;
        if (w == 4) begin s4 = 1'b1; a4 = a[3:0]; b4 = b[3:0]; sm4 = sm; end
        else        begin s8 = 1'b1; a8 = a;      b8 = b;      sm8 = sm; end
        @(posedge clk); #1;
        s4 = 1'b0; s8 = 1'b0;
        a4 = ~a4; b4 = b4 + 4'd5; sm4 = ~sm4;
        a8 = ~a8; b8 = b8 + 8'd37; sm8 = ~sm8;
        rdy_ok   = (cur_ready(w) == (el == 1));
        lat      = -1;
        p        = 16'h0;
        pulse_ok = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (cur_done(w)) begin
                lat = k;
                if (!cur_ready(w)) rdy_ok = 1'b0;
                break;
            end
            if (cur_ready(w)) rdy_ok = 1'b0;
        end
        if (lat > 0) begin
            p = (w == 4) ? {8'h00, p4} : p8;
            @(posedge clk); #1;
            pulse_ok = !cur_done(w) && cur_ready(w);
        end
    endtask

    logic [15:0] p;
    int          lat;
    bit          rdy_ok, pulse_ok;
    bit          seen;

    initial begin
        vecs[0] = '{4, 8'h05, 8'h06, 1'b0, 16'h001E};
        vecs[1] = '{4, 8'h08, 8'h07, 1'b1, 16'h00C8};
        vecs[2] = '{4, 8'h0F, 8'h0F, 1'b0, 16'h00E1};
        vecs[3] = '{8, 8'h80, 8'h80, 1'b1, 16'h4000};
        vecs[4] = '{8, 8'hFF, 8'hFF, 1'b0, 16'hFE01};
        vecs[5] = '{4, 8'h00, 8'h09, 1'b0, 16'h0000};
        vecs[6] = '{4, 8'h08, 8'h08, 1'b1, 16'h0040};
        vecs[7] = '{8, 8'h7F, 8'h80, 1'b1, 16'hC080};
        vecs[8] = '{4, 8'h0F, 8'h0F, 1'b1, 16'h0001};
        vecs[9] = '{4, 8'h0F, 8'h08, 1'b0, 16'h0078};

        reset = 1'b0;
        s4 = 0; sm4 = 0; a4 = 0; b4 = 0;
        s8 = 0; sm8 = 0; a8 = 0; b8 = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_p4", p4, 0);
        check("reset_p8", p8, 0);
        check("reset_ready", {r4, r8}, 2'b11);
        check("reset_done", {d4, d8}, 2'b00);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].sm, p, lat, rdy_ok, pulse_ok);
            check($sformatf("vec%0d_p", i), p, vecs[i].p);
            check($sformatf("vec%0d_lat", i), lat, exp_lat(vecs[i].w, vecs[i].a, vecs[i].b));
            check($sformatf("vec%0d_ready", i), rdy_ok, 1);
            check($sformatf("vec%0d_pulse", i), pulse_ok, 1);
        end

        // Start pulsed while busy must be dropped, not queued
        @(posedge clk); #1;
        s4 = 1'b1; a4 = 4'd3; b4 = 4'd3; sm4 = 1'b0;
        @(posedge clk); #1;
        s4 = 1'b0; a4 = 4'd7; b4 = 4'd7;
        @(posedge clk); #1;
        s4 = 1'b1;
        @(posedge clk); #1;
        s4 = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            if (d4) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("busy_done_seen", seen, 1);
        check("busy_p", p4, 8'h09);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (d4) seen = 1'b1;
        end
        check("busy_no_extra_done", seen, 0);
        check("busy_p_hold", p4, 8'h09);
        do_op(4, 8'h07, 8'h07, 1'b0, p, lat, rdy_ok, pulse_ok);
        check("third_p", p, 16'h0031);
        check("third_lat", lat, 3);

        // Reset in the second CALC cycle aborts without done and clears P
        @(posedge clk); #1;
        s4 = 1'b1; a4 = 4'd5; b4 = 4'd6; sm4 = 1'b0;
        @(posedge clk); #1;
        s4 = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        seen = d4;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (d4) seen = 1'b1;
        end
        check("abort_no_done", seen, 0);
        check("abort_p", p4, 0);
        check("abort_ready", r4, 1);
        do_op(4, 8'h02, 8'h03, 1'b0, p, lat, rdy_ok, pulse_ok);
        check("after_abort_p", p, 16'h0006);
        check("after_abort_lat", lat, 3);

        for (int i = 0; i < 40; i++) begin
            int          w;
            logic [7:0]  ra, rb;
            logic        rs;
            w  = ($urandom_range(0, 1) == 1) ? 8 : 4;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            if (w == 4) begin ra = ra & 8'h0F; rb = rb & 8'h0F; end
            if ($urandom_range(0, 7) == 0) ra = 8'h00;
            do_op(w, ra, rb, rs, p, lat, rdy_ok, pulse_ok);
            check($sformatf("rand%0d_w%0d_%0h_%0h_s%0d_p", i, w, ra, rb, rs), p, ref_mult(w, ra, rb, rs));
            check($sformatf("rand%0d_lat", i), lat, exp_lat(w, ra, rb));
            check($sformatf("rand%0d_hs", i), {rdy_ok, pulse_ok}, 2'b11);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
